// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one functional-unit result per cycle onto the registered common data bus.
// Define CDB_ARB_AGE_PRIORITY_EN for oldest-ROB-entry-first selection; the default build uses round-robin.
module cdb_arbiter #(
  parameter int unsigned NUM_FU   = 4,
  parameter int unsigned ROB_SIZE = 8,
  localparam int unsigned ROB_IX  = $clog2(ROB_SIZE) - 1,
  localparam int unsigned PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [ROB_IX:0]                rob_head_in,
  input  logic                           flush_in,
  input  logic [NUM_FU-1:0]              fu_valid_in,
  input  logic [NUM_FU-1:0][ROB_IX:0]    fu_rob_ix_in,
  input  logic [NUM_FU-1:0][31:0]        fu_value_in,
  input  logic [NUM_FU-1:0][31:0]        fu_dest_in,
  output logic [NUM_FU-1:0]              fu_ready_out,
  output logic                           cdb_valid_out,
  output logic [ROB_IX:0]                cdb_rob_ix_out,
  output logic signed [31:0]             cdb_value_out,
  output logic signed [31:0]             cdb_dest_out,
  output logic [15:0]                    grant_count_out
);

  logic             win_found;
  logic [PTR_W-1:0] win_ix;
  logic             transfer;

  logic             cdb_valid_q, cdb_valid_d;
  logic [ROB_IX:0]  cdb_rob_ix_q, cdb_rob_ix_d;
  logic [31:0]      cdb_value_q, cdb_value_d;
  logic [31:0]      cdb_dest_q, cdb_dest_d;
  logic [15:0]      grant_count_q, grant_count_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

`ifdef CDB_ARB_AGE_PRIORITY_EN
  logic [ROB_IX:0]  best_age;
  logic [ROB_IX:0]  age;
  logic             unused_rr;

  // Strict less-than keeps the lowest FU index on equal ages.
  always_comb begin
    win_found = 1'b0;
    win_ix    = '0;
    best_age  = '0;
    age       = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      age = fu_rob_ix_in[i] - rob_head_in;
      if (fu_valid_in[i] && (!win_found || age < best_age)) begin
        win_found = 1'b1;
        win_ix    = PTR_W'(i);
        best_age  = age;
      end
    end
  end

  assign unused_rr = ^rr_ptr_d;
`else
  int unsigned cand;
  logic        unused_head;

  always_comb begin
    win_found = 1'b0;
    win_ix    = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      cand = (32'(rr_ptr_q) + off) % NUM_FU;
      if (!win_found && fu_valid_in[cand]) begin
        win_found = 1'b1;
        win_ix    = PTR_W'(cand);
      end
    end
  end

  assign unused_head = ^rob_head_in;
`endif

  // Reset and flush both mask the grant combinationally.
  assign transfer     = win_found && !flush_in && rst_n_in;
  assign fu_ready_out = transfer ? (NUM_FU'(1) << win_ix) : '0;

  always_comb begin
    cdb_valid_d   = 1'b0;
    cdb_rob_ix_d  = cdb_rob_ix_q;
    cdb_value_d   = cdb_value_q;
    cdb_dest_d    = cdb_dest_q;
    grant_count_d = grant_count_q;
    rr_ptr_d      = rr_ptr_q;
    if (flush_in) begin
      cdb_rob_ix_d = '0;
      cdb_value_d  = '0;
      cdb_dest_d   = '0;
    end else if (transfer) begin
      cdb_valid_d  = 1'b1;
      cdb_rob_ix_d = fu_rob_ix_in[win_ix];
      cdb_value_d  = fu_value_in[win_ix];
      cdb_dest_d   = fu_dest_in[win_ix];
      rr_ptr_d     = PTR_W'((32'(win_ix) + 1) % NUM_FU);
      if (grant_count_q != '1) begin
        grant_count_d = grant_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_q   <= 1'b0;
      cdb_rob_ix_q  <= '0;
      cdb_value_q   <= '0;
      cdb_dest_q    <= '0;
      grant_count_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_ix_q  <= cdb_rob_ix_d;
      cdb_value_q   <= cdb_value_d;
      cdb_dest_q    <= cdb_dest_d;
      grant_count_q <= grant_count_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign cdb_valid_out   = cdb_valid_q;
  assign cdb_rob_ix_out  = cdb_rob_ix_q;
  assign cdb_value_out   = cdb_value_q;
  assign cdb_dest_out    = cdb_dest_q;
  assign grant_count_out = grant_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (round-robin by default, age order with CDB_ARB_AGE_PRIORITY_EN).
module tb_cdb_arbiter;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in;
  logic [2:0]           rob_head_in;
  logic                 flush_in;
  logic [3:0]           fu_valid_in;
  logic [3:0][2:0]      fu_rob_ix_in;
  logic [3:0][31:0]     fu_value_in;
  logic [3:0][31:0]     fu_dest_in;
  logic [3:0]           fu_ready_out;
  logic                 cdb_valid_out;
  logic [2:0]           cdb_rob_ix_out;
  logic signed [31:0]   cdb_value_out;
  logic signed [31:0]   cdb_dest_out;
  logic [15:0]          grant_count_out;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  cdb_arbiter #(.NUM_FU(4), .ROB_SIZE(8)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rob_head_in     (rob_head_in),
    .flush_in        (flush_in),
    .fu_valid_in     (fu_valid_in),
    .fu_rob_ix_in    (fu_rob_ix_in),
    .fu_value_in     (fu_value_in),
    .fu_dest_in      (fu_dest_in),
    .fu_ready_out    (fu_ready_out),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_rob_ix_out  (cdb_rob_ix_out),
    .cdb_value_out   (cdb_value_out),
    .cdb_dest_out    (cdb_dest_out),
    .grant_count_out (grant_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #2;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in     = 1'b0;
    rob_head_in  = '0;
    flush_in     = 1'b0;
    fu_valid_in  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fu_rob_ix_in[i] = 3'(i);
      fu_value_in[i]  = 32'hA0 + 32'(i);
      fu_dest_in[i]   = 32'hD0 + 32'(i);
    end

    // Reset state with requests present
    #12;
    check_eq("rst_ready", 64'(fu_ready_out), 64'h0);
    check_eq("rst_valid", 64'(cdb_valid_out), 64'h0);
    check_eq("rst_count", 64'(grant_count_out), 64'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // All four FUs held valid for 8 cycles
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef CDB_ARB_AGE_PRIORITY_EN
      check_eq("age_all_ready", 64'(fu_ready_out), 64'h1);
`else
      check_eq("rr_ready", 64'(fu_ready_out), 64'(4'b0001 << (k % 4)));
`endif
      @(posedge clk_in);
      #1;
      check_eq("all_cdb_valid", 64'(cdb_valid_out), 64'h1);
`ifndef CDB_ARB_AGE_PRIORITY_EN
      check_eq("rr_cdb_ix", 64'(cdb_rob_ix_out), 64'(k % 4));
      check_eq("rr_cdb_value", 64'(cdb_value_out), 64'(32'hA0 + 32'(k % 4)));
      check_eq("rr_cdb_dest", 64'(cdb_dest_out), 64'(32'hD0 + 32'(k % 4)));
`endif
      @(negedge clk_in);
    end
    fu_valid_in = 4'b0000;
    check_eq("all_count8", 64'(grant_count_out), 64'd8);
    @(posedge clk_in);
    #1;
    check_eq("idle_valid", 64'(cdb_valid_out), 64'h0);

    // Asynchronous reset while a broadcast is on the bus
    @(negedge clk_in);
    fu_valid_in = 4'b0001;
    @(posedge clk_in);
    #1;
    check_eq("pre_rst_valid", 64'(cdb_valid_out), 64'h1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(cdb_valid_out), 64'h0);
    check_eq("async_rst_ready", 64'(fu_ready_out), 64'h0);
    check_eq("async_rst_count", 64'(grant_count_out), 64'h0);
    @(negedge clk_in);
    fu_valid_in = 4'b0000;
    rst_n_in    = 1'b1;
    @(posedge clk_in);
    #1;
    check_eq("post_rst_valid", 64'(cdb_valid_out), 64'h0);
    check_eq("post_rst_ix", 64'(cdb_rob_ix_out), 64'h0);
    check_eq("post_rst_value", 64'(cdb_value_out), 64'h0);
    check_eq("post_rst_dest", 64'(cdb_dest_out), 64'h0);

    // Single request from FU2
    @(negedge clk_in);
    rob_head_in     = 3'd0;
    fu_rob_ix_in[2] = 3'd3;
    fu_value_in[2]  = 32'h1234;
    fu_dest_in[2]   = 32'h55;
    fu_valid_in     = 4'b0100;
    #1;
    check_eq("single_ready", 64'(fu_ready_out), 64'h4);
    @(posedge clk_in);
    #1;
    check_eq("single_valid", 64'(cdb_valid_out), 64'h1);
    check_eq("single_ix", 64'(cdb_rob_ix_out), 64'h3);
    check_eq("single_value", 64'(cdb_value_out), 64'h1234);
    check_eq("single_dest", 64'(cdb_dest_out), 64'h55);
    fu_valid_in = 4'b0000;
    @(posedge clk_in);
    #1;
    check_eq("single_drop_valid", 64'(cdb_valid_out), 64'h0);
    check_eq("single_hold_value", 64'(cdb_value_out), 64'h1234);
    check_eq("single_count", 64'(grant_count_out), 64'h1);

    // Flush with FU0 and FU1 requesting
    @(negedge clk_in);
    fu_rob_ix_in[0] = 3'd1;
    fu_rob_ix_in[1] = 3'd2;
    fu_valid_in     = 4'b0011;
    flush_in        = 1'b1;
    #1;
    check_eq("flush_ready", 64'(fu_ready_out), 64'h0);
    @(posedge clk_in);
    #1;
    check_eq("flush_valid", 64'(cdb_valid_out), 64'h0);
    check_eq("flush_count", 64'(grant_count_out), 64'h1);
    @(negedge clk_in);
    flush_in = 1'b0;
    #1;
    check_eq("resume_ready", 64'(fu_ready_out), 64'h1);
    @(posedge clk_in);
    #1;
    check_eq("resume_valid", 64'(cdb_valid_out), 64'h1);
    check_eq("resume_ix", 64'(cdb_rob_ix_out), 64'h1);
    @(negedge clk_in);
    fu_valid_in = 4'b0000;

`ifdef CDB_ARB_AGE_PRIORITY_EN
    // Age order across ROB wrap: head=6 -> ix7 age1, ix0 age2, ix1 age3
    @(negedge clk_in);
    rob_head_in     = 3'd6;
    fu_rob_ix_in[0] = 3'd1;
    fu_rob_ix_in[1] = 3'd7;
    fu_rob_ix_in[3] = 3'd0;
    fu_valid_in     = 4'b1011;
    #1;
    check_eq("wrap_ready0", 64'(fu_ready_out), 64'h2);
    @(posedge clk_in);
    #1;
    fu_valid_in = 4'b1001;
    check_eq("wrap_ix0", 64'(cdb_rob_ix_out), 64'h7);
    check_eq("wrap_ready1", 64'(fu_ready_out), 64'h8);
    @(posedge clk_in);
    #1;
    fu_valid_in = 4'b0001;
    check_eq("wrap_ix1", 64'(cdb_rob_ix_out), 64'h0);
    check_eq("wrap_valid1", 64'(cdb_valid_out), 64'h1);
    check_eq("wrap_ready2", 64'(fu_ready_out), 64'h1);
    @(posedge clk_in);
    #1;
    fu_valid_in = 4'b0000;
    check_eq("wrap_ix2", 64'(cdb_rob_ix_out), 64'h1);
    check_eq("wrap_valid2", 64'(cdb_valid_out), 64'h1);
`else
    // Pointer is 1 after FU0 won: FU3 ahead of FU0, then FU0
    @(negedge clk_in);
    fu_rob_ix_in[0] = 3'd1;
    fu_rob_ix_in[3] = 3'd6;
    fu_valid_in     = 4'b1001;
    #1;
    check_eq("rr_skip_ready0", 64'(fu_ready_out), 64'h8);
    @(posedge clk_in);
    #1;
    fu_valid_in = 4'b0001;
    check_eq("rr_skip_ix0", 64'(cdb_rob_ix_out), 64'h6);
    check_eq("rr_skip_ready1", 64'(fu_ready_out), 64'h1);
    @(posedge clk_in);
    #1;
    fu_valid_in = 4'b0000;
    check_eq("rr_skip_ix1", 64'(cdb_rob_ix_out), 64'h1);
    check_eq("rr_skip_valid1", 64'(cdb_valid_out), 64'h1);
`endif

    // Saturating grant counter
    apply_reset();
    fu_valid_in = 4'b0001;
    repeat (65535) @(posedge clk_in);
    #1;
    check_eq("sat_reach", 64'(grant_count_out), 64'hFFFF);
    check_eq("sat_ready", 64'(fu_ready_out), 64'h1);
    @(posedge clk_in);
    #1;
    check_eq("sat_hold", 64'(grant_count_out), 64'hFFFF);
    check_eq("sat_valid", 64'(cdb_valid_out), 64'h1);
    fu_valid_in = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
